// File: rtl/mem_word_adapter.sv
// Splits one 32-bit MCU word request into two halfword accesses on a 16-bit
// byte-enabled RAM (low halfword first) and reassembles read data.
module mem_word_adapter #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [3:0]            mem_be,
    input  logic [ADDR_WIDTH-2:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_busy,
    output logic                  mem_ack,
    output logic [31:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]           ram_din,
    output logic [1:0]            ram_write_en,
    input  logic [15:0]           ram_dout
);

    localparam int unsigned WORD_AW = ADDR_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        CAP  = 2'd3
    } state_t;

    state_t               state;
    logic [WORD_AW-1:0]   addr_q;
    logic                 we_q;
    logic [3:0]           be_q;
    logic [31:0]          wdata_q;
    logic [15:0]          lo_cap;

    // Outputs are loaded one edge ahead so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= 4'b0000;
            wdata_q      <= 32'h0;
            lo_cap       <= 16'h0;
            mem_busy     <= 1'b0;
            mem_ack      <= 1'b0;
            mem_rdata    <= 32'h0;
            ram_addr     <= '0;
            ram_din      <= 16'h0;
            ram_write_en <= 2'b00;
        end else begin
            mem_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        addr_q       <= mem_addr;
                        we_q         <= mem_we;
                        be_q         <= mem_be;
                        wdata_q      <= mem_wdata;
                        ram_addr     <= {mem_addr, 1'b0};
                        ram_din      <= mem_wdata[15:0];
                        ram_write_en <= mem_we ? mem_be[1:0] : 2'b00;
                        mem_busy     <= 1'b1;
                        state        <= LO;
                    end
                end
                LO: begin
                    ram_addr     <= {addr_q, 1'b1};
                    ram_din      <= wdata_q[31:16];
                    ram_write_en <= we_q ? be_q[3:2] : 2'b00;
                    state        <= HI;
                end
                HI: begin
                    ram_write_en <= 2'b00;
                    if (we_q) begin
                        mem_ack  <= 1'b1;
                        mem_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        // RAM output now carries the low halfword read issued in LO.
                        lo_cap <= ram_dout;
                        state  <= CAP;
                    end
                end
                CAP: begin
                    mem_rdata <= {ram_dout, lo_cap};
                    mem_ack   <= 1'b1;
                    mem_busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    ram_write_en <= 2'b00;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_word_adapter.sv
// Directed bench for mem_word_adapter with a behavioural 16-bit byte-enabled RAM
// (1-cycle registered read) attached to the RAM side.
module tb_mem_word_adapter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_busy;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [11:0] ram_addr;
    logic [15:0] ram_din;
    logic [1:0]  ram_write_en;
    logic [15:0] ram_dout;

    logic [15:0] ram [0:4095];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_word_adapter #(.ADDR_WIDTH(12)) dut (
        .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_busy(mem_busy), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_write_en(ram_write_en),
        .ram_dout(ram_dout)
    );

    // Byte-enabled RAM, read-before-write, registered output.
    always @(posedge clk) begin
        if (ram_write_en[0]) ram[ram_addr][7:0]  <= ram_din[7:0];
        if (ram_write_en[1]) ram[ram_addr][15:8] <= ram_din[15:8];
        ram_dout <= ram[ram_addr];
    end

    task automatic drive_req(input logic we, input logic [3:0] be,
                             input logic [10:0] addr, input logic [31:0] wdata);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_be    = be;
        mem_addr  = addr;
        mem_wdata = wdata;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_req(1'b1, 4'hF, 11'h123, 32'h55AA55AA);
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h want 0", mem_busy); end
        checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %h want 0", mem_ack); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", mem_rdata); end
        checks++; if (ram_addr !== 12'h0) begin errors++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
        checks++; if (ram_din !== 16'h0) begin errors++; $display("FAIL reset_ram_din got %h want 0", ram_din); end
        checks++; if (ram_write_en !== 2'b00) begin errors++; $display("FAIL reset_write_en got %b want 00", ram_write_en); end
        mem_req = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (ram[12'h246] !== 16'h0) begin errors++; $display("FAIL reset_no_write got %h want 0", ram[12'h246]); end
    endtask

    task automatic test_full_write();
        drive_req(1'b1, 4'hF, 11'h005, 32'hDEADBEEF);
        @(negedge clk);
        mem_req = 1'b0;
        checks++; if (ram_addr !== 12'h00A) begin errors++; $display("FAIL wr_lo_addr got %h want 00a", ram_addr); end
        checks++; if (ram_din !== 16'hBEEF) begin errors++; $display("FAIL wr_lo_din got %h want beef", ram_din); end
        checks++; if (ram_write_en !== 2'b11) begin errors++; $display("FAIL wr_lo_we got %b want 11", ram_write_en); end
        checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL wr_lo_busy got %h want 1", mem_busy); end
        @(negedge clk);
        checks++; if (ram_addr !== 12'h00B) begin errors++; $display("FAIL wr_hi_addr got %h want 00b", ram_addr); end
        checks++; if (ram_din !== 16'hDEAD) begin errors++; $display("FAIL wr_hi_din got %h want dead", ram_din); end
        checks++; if (ram_write_en !== 2'b11) begin errors++; $display("FAIL wr_hi_we got %b want 11", ram_write_en); end
        checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL wr_hi_ack got %h want 0", mem_ack); end
        @(negedge clk);
        checks++; if (mem_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %h want 1", mem_ack); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL wr_ack_busy got %h want 0", mem_busy); end
        checks++; if (ram_write_en !== 2'b00) begin errors++; $display("FAIL wr_ack_we got %b want 00", ram_write_en); end
        @(negedge clk);
        checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_drop got %h want 0", mem_ack); end
        checks++; if ({ram[12'h00B], ram[12'h00A]} !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_ram got %h want deadbeef", {ram[12'h00B], ram[12'h00A]}); end
    endtask

    task automatic test_read(input logic [10:0] addr, input logic [31:0] exp);
        drive_req(1'b0, 4'hF, addr, 32'hFFFFFFFF);
        @(negedge clk);
        mem_req = 1'b0;
        checks++; if (ram_addr !== {addr, 1'b0}) begin errors++; $display("FAIL rd_lo_addr got %h want %h", ram_addr, {addr, 1'b0}); end
        checks++; if (ram_write_en !== 2'b00) begin errors++; $display("FAIL rd_lo_we got %b want 00", ram_write_en); end
        @(negedge clk);
        checks++; if (ram_addr !== {addr, 1'b1}) begin errors++; $display("FAIL rd_hi_addr got %h want %h", ram_addr, {addr, 1'b1}); end
        checks++; if (ram_write_en !== 2'b00) begin errors++; $display("FAIL rd_hi_we got %b want 00", ram_write_en); end
        @(negedge clk);
        checks++; if (mem_ack !== 1'b0 || mem_busy !== 1'b1) begin errors++; $display("FAIL rd_cap got ack %h busy %h want ack 0 busy 1", mem_ack, mem_busy); end
        @(negedge clk);
        checks++; if (mem_ack !== 1'b1) begin errors++; $display("FAIL rd_ack got %h want 1", mem_ack); end
        checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL rd_data got %h want %h", mem_rdata, exp); end
        @(negedge clk);
        checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_drop got %h want 0", mem_ack); end
        checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL rd_hold got %h want %h", mem_rdata, exp); end
    endtask

    task automatic test_partial_write();
        drive_req(1'b1, 4'b0110, 11'h005, 32'h11223344);
        @(negedge clk);
        mem_req = 1'b0;
        checks++; if (ram_write_en !== 2'b10) begin errors++; $display("FAIL part_lo_we got %b want 10", ram_write_en); end
        @(negedge clk);
        checks++; if (ram_write_en !== 2'b01) begin errors++; $display("FAIL part_hi_we got %b want 01", ram_write_en); end
        @(negedge clk);
        checks++; if (mem_ack !== 1'b1) begin errors++; $display("FAIL part_ack got %h want 1", mem_ack); end
        @(negedge clk);
        test_read(11'h005, 32'hDE2233EF);
    endtask

    task automatic test_zero_mask();
        drive_req(1'b1, 4'b0000, 11'h005, 32'hFFFFFFFF);
        @(negedge clk);
        mem_req = 1'b0;
        checks++; if (ram_write_en !== 2'b00) begin errors++; $display("FAIL zero_lo_we got %b want 00", ram_write_en); end
        @(negedge clk);
        checks++; if (ram_write_en !== 2'b00) begin errors++; $display("FAIL zero_hi_we got %b want 00", ram_write_en); end
        @(negedge clk);
        checks++; if (mem_ack !== 1'b1) begin errors++; $display("FAIL zero_ack got %h want 1", mem_ack); end
        @(negedge clk);
        test_read(11'h005, 32'hDE2233EF);
    endtask

    task automatic test_back_to_back();
        drive_req(1'b1, 4'hF, 11'h010, 32'hCAFEF00D);
        @(negedge clk);
        drive_req(1'b1, 4'hF, 11'h020, 32'h99999999);
        @(negedge clk);
        checks++; if (ram_addr !== 12'h021) begin errors++; $display("FAIL b2b_hi_addr got %h want 021", ram_addr); end
        @(negedge clk);
        checks++; if (mem_ack !== 1'b1) begin errors++; $display("FAIL b2b_wr_ack got %h want 1", mem_ack); end
        drive_req(1'b0, 4'hF, 11'h010, 32'h0);
        @(negedge clk);
        mem_req = 1'b0;
        checks++; if (mem_busy !== 1'b1 || ram_addr !== 12'h020) begin errors++; $display("FAIL b2b_rd_lo got busy %h addr %h want busy 1 addr 020", mem_busy, ram_addr); end
        checks++; if (mem_ack !== 1'b0 || ram_write_en !== 2'b00) begin errors++; $display("FAIL b2b_rd_lo_ctl got ack %h we %b want ack 0 we 00", mem_ack, ram_write_en); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL b2b_rd_early got %h want 0", mem_ack); end
        @(negedge clk);
        checks++; if (mem_ack !== 1'b1 || mem_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_rd_data got ack %h data %h want ack 1 data cafef00d", mem_ack, mem_rdata); end
        @(negedge clk);
        checks++; if (mem_ack !== 1'b0 || mem_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got ack %h busy %h want 0 0", mem_ack, mem_busy); end
        checks++; if ({ram[12'h041], ram[12'h040]} !== 32'h0) begin errors++; $display("FAIL b2b_ignored got %h want 0", {ram[12'h041], ram[12'h040]}); end
    endtask

    task automatic test_reset_mid_write();
        int acks;
        drive_req(1'b1, 4'hF, 11'h7FF, 32'h12345678);
        @(negedge clk);
        mem_req = 1'b0;
        checks++; if (ram_addr !== 12'hFFE || ram_write_en !== 2'b11) begin errors++; $display("FAIL mid_lo got addr %h we %b want ffe 11", ram_addr, ram_write_en); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (ram_write_en !== 2'b00 || mem_busy !== 1'b0) begin errors++; $display("FAIL mid_rst got we %b busy %h want 00 0", ram_write_en, mem_busy); end
        reset_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_ack === 1'b1) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL mid_no_ack got %0d want 0", acks); end
        checks++; if (ram[12'hFFE] !== 16'h5678) begin errors++; $display("FAIL mid_lo_ram got %h want 5678", ram[12'hFFE]); end
        checks++; if (ram[12'hFFF] !== 16'hA5A5) begin errors++; $display("FAIL mid_hi_ram got %h want a5a5", ram[12'hFFF]); end
        test_read(11'h7FF, 32'hA5A55678);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
        ram[4095] = 16'hA5A5;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = 11'h0;
        mem_wdata = 32'h0;
        reset_n   = 1'b0;
        test_reset();
        test_full_write();
        test_read(11'h005, 32'hDEADBEEF);
        test_partial_write();
        test_zero_mask();
        test_back_to_back();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
